// File: rtl/fsb_region_controller.sv
// Front-side-bus region decoder and access sequencer.
// Decodes the request address against REGIONS base/limit windows, inserts
// per-region wait states, waits for the region's ready with a timeout, and
// reports unmapped/timed-out accesses through a sticky error flag.
module fsb_region_controller #(
    parameter int unsigned REGIONS    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WAIT_WIDTH = 4,
    parameter int unsigned TIMEOUT    = 16,
    // Region i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH] (region 0 in the LSBs).
    parameter logic [REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
        {32'h0000_2010, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [REGIONS*ADDR_WIDTH-1:0] REGION_LIMIT =
        {32'h0000_3000, 32'h0000_2010, 32'h0000_2000, 32'h0000_1000},
    parameter logic [REGIONS*WAIT_WIDTH-1:0] REGION_WAIT =
        {4'd0, 4'd1, 4'd2, 4'd0}
) (
    input  logic                          iBusClock,
    input  logic                          iBusReset,
    input  logic                          iRequest,
    input  logic                          iWrite,
    input  logic [ADDR_WIDTH-1:0]         iAddress,
    input  logic [REGIONS*DATA_WIDTH-1:0] iRegionData,
    input  logic [REGIONS-1:0]            iRegionReady,
    input  logic                          iErrorClear,
    output logic [REGIONS-1:0]            oSelect,
    output logic                          oWrite,
    output logic [DATA_WIDTH-1:0]         oReadData,
    output logic                          oReady,
    output logic                          oError,
    output logic [ADDR_WIDTH-1:0]         oErrorAddress
);

    localparam int unsigned IDX_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} stateType;

    stateType               state, stateNext;
    logic [IDX_W-1:0]       region, regionNext;
    logic [ADDR_WIDTH-1:0]  address, addressNext;
    logic [WAIT_WIDTH-1:0]  waitCount, waitNext;
    logic [7:0]             timeoutCount, timeoutNext;
    logic [REGIONS-1:0]     selectNext;
    logic                   writeNext;
    logic [DATA_WIDTH-1:0]  readDataNext;
    logic                   readyNext;
    logic                   errorNext;
    logic [ADDR_WIDTH-1:0]  errorAddressNext;
    logic                   errorEvent;
    logic [ADDR_WIDTH-1:0]  faultAddress;
    logic                   hit;
    logic [IDX_W-1:0]       hitIndex;

    // Address decode; scanning downwards lets the lowest overlapping index win.
    always_comb begin
        hit      = 1'b0;
        hitIndex = '0;
        for (int i = REGIONS - 1; i >= 0; i--) begin
            if (iAddress >= REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] &&
                iAddress <  REGION_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit      = 1'b1;
                hitIndex = IDX_W'(i);
            end
        end
    end

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        stateNext    = state;
        regionNext   = region;
        addressNext  = address;
        waitNext     = waitCount;
        timeoutNext  = timeoutCount;
        selectNext   = oSelect;
        writeNext    = oWrite;
        readDataNext = oReadData;
        readyNext    = 1'b0;
        errorEvent   = 1'b0;
        faultAddress = address;

        case (state)
            StIdle: begin
                if (iRequest) begin
                    addressNext = iAddress;
                    if (hit) begin
                        regionNext           = hitIndex;
                        writeNext            = iWrite;
                        selectNext           = '0;
                        selectNext[hitIndex] = 1'b1;
                        waitNext    = REGION_WAIT[hitIndex*WAIT_WIDTH +: WAIT_WIDTH];
                        timeoutNext = '0;
                        stateNext   = StAccess;
                    end else begin
                        selectNext   = '0;
                        writeNext    = 1'b0;
                        readDataNext = '0;
                        readyNext    = 1'b1;
                        errorEvent   = 1'b1;
                        faultAddress = iAddress;
                        stateNext    = StDone;
                    end
                end
            end
            StAccess: begin
                if (!iRequest) begin
                    // Master withdrew the request: abort silently.
                    selectNext = '0;
                    writeNext  = 1'b0;
                    stateNext  = StIdle;
                end else if (waitCount != '0) begin
                    waitNext = waitCount - 1'b1;
                end else if (iRegionReady[region]) begin
                    if (!oWrite) begin
                        readDataNext = iRegionData[region*DATA_WIDTH +: DATA_WIDTH];
                    end
                    readyNext = 1'b1;
                    stateNext = StDone;
                end else if (timeoutCount == TIMEOUT_CNT) begin
                    readDataNext = '0;
                    readyNext    = 1'b1;
                    errorEvent   = 1'b1;
                    stateNext    = StDone;
                end else begin
                    timeoutNext = timeoutCount + 8'd1;
                end
            end
            StDone: begin
                selectNext = '0;
                writeNext  = 1'b0;
                stateNext  = StIdle;
            end
            default: begin
                selectNext = '0;
                writeNext  = 1'b0;
                stateNext  = StIdle;
            end
        endcase

        // A new error beats a simultaneous clear; only the first fault address sticks.
        if (errorEvent) begin
            errorNext = 1'b1;
        end else if (iErrorClear) begin
            errorNext = 1'b0;
        end else begin
            errorNext = oError;
        end
        errorAddressNext = (errorEvent && !oError) ? faultAddress : oErrorAddress;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge iBusClock or negedge iBusReset) begin
        if (!iBusReset) begin
            state         <= StIdle;
            region        <= '0;
            address       <= '0;
            waitCount     <= '0;
            timeoutCount  <= '0;
            oSelect       <= '0;
            oWrite        <= 1'b0;
            oReadData     <= '0;
            oReady        <= 1'b0;
            oError        <= 1'b0;
            oErrorAddress <= '0;
        end else begin
            state         <= stateNext;
            region        <= regionNext;
            address       <= addressNext;
            waitCount     <= waitNext;
            timeoutCount  <= timeoutNext;
            oSelect       <= selectNext;
            oWrite        <= writeNext;
            oReadData     <= readDataNext;
            oReady        <= readyNext;
            oError        <= errorNext;
            oErrorAddress <= errorAddressNext;
        end
    end

endmodule

// File: doc/fsb_region_controller.md
Name: fsb_region_controller

Overview:
- Parametrised front-side-bus address decoder and access sequencer for epRISC machine-level integration.
- Replaces fixed compare-and-enable region decoding with N configurable regions, each with:
  - per-region wait states,
  - a ready handshake,
  - a timeout.
- Unmapped or timed-out accesses return zero data and raise a sticky bus-error flag with the faulting address captured.
- Sits between the core's bus interface and the ROM/RAM/peripheral regions.

Parameters:
- REGIONS, 4, number of decoded regions (1..16).
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width.
- WAIT_WIDTH, 4, width of each per-region wait-state count.
- TIMEOUT, 16, cycles to wait for region ready after wait states elapse (1..255).
- REGION_BASE, {0x0,0x1000,0x2000,0x2010}, flat vector of REGIONS×ADDR_WIDTH inclusive base addresses.
- REGION_LIMIT, {0x1000,0x2000,0x2010,0x3000}, flat vector of exclusive limits (address < limit).
- REGION_WAIT, {0,2,1,0}, flat vector of REGIONS×WAIT_WIDTH wait-state counts.

Ports:
- iBusClock  in  1  bus clock.
- iBusReset  in  1  asynchronous, active-low reset.
- iRequest  in  1  access request; must be held until oReady.
- iWrite  in  1  1 = write, 0 = read; sampled at accept.
- iAddress  in  ADDR_WIDTH  access address; sampled at accept.
- iRegionData  in  REGIONS×DATA_WIDTH  read data from each region, region i at bits [i×DATA_WIDTH +: DATA_WIDTH].
- iRegionReady  in  REGIONS  per-region ready; tie high for fixed-latency regions.
- iErrorClear  in  1  clears oError.
- oSelect  out  REGIONS  one-hot region select.
- oWrite  out  1  registered write qualifier, valid while oSelect is nonzero.
- oReadData  out  DATA_WIDTH  registered read data.
- oReady  out  1  one-cycle access-complete pulse.
- oError  out  1  sticky bus error.
- oErrorAddress  out  ADDR_WIDTH  address of the first error since the last clear.

Behaviour:
- Reset (asynchronous, iBusReset=0):
  - State is IDLE.
  - oSelect=0, oWrite=0, oReadData=0, oReady=0, oError=0, oErrorAddress=0.
  - Counters are 0.
  - Reset mid-access aborts immediately with no oReady.
- Decode:
  - Region i hits when REGION_BASE[i] <= iAddress < REGION_LIMIT[i].
  - On overlap, the lowest index wins.
  - No hit means unmapped.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On an edge with iRequest=1 and a hit on region i: latch region, iWrite and iAddress; set oSelect[i]=1 and oWrite; load wait counter = REGION_WAIT[i] and timeout counter = 0; go to ACCESS.
  - On an edge with iRequest=1 and no hit: go to DONE with oReady=1, oReadData=0, error event.
- ACCESS, evaluated each edge:
  - Wait counter ≠ 0: decrement it.
  - Else if iRegionReady[i]=1: for a read, latch the iRegionData slice into oReadData; for a write, oReadData holds its value. Go to DONE with oReady=1.
  - Else increment the timeout counter. When it reaches TIMEOUT, go to DONE with oReady=1, oReadData=0, error event.
  - iRequest=0 at any edge: abort to IDLE, clear oSelect, no oReady, no error.
- DONE:
  - oReady=1 for exactly this cycle; oSelect is still asserted (0 for unmapped).
  - Next edge: go to IDLE, clear oSelect and oReady.
  - A new request is accepted no earlier than the edge after returning to IDLE.
- Latency, accept edge to oReady=1 with ready high: 1+W cycles, where W = wait count.
  - Unmapped: oReady is asserted in the cycle immediately after the accept edge.
  - Timeout: oReady=1 at 1+W+TIMEOUT.
- Error event:
  - Sets oError.
  - Captures the address into oErrorAddress only if oError was 0.
- Error clear:
  - iErrorClear=1 clears oError.
  - Error event and iErrorClear on the same edge: the error wins, and the address is captured.
- Widths:
  - Wait counter is WAIT_WIDTH bits; timeout counter is 8 bits.
  - Counters never wrap: the wait counter stops at 0, and the timeout counter stops at TIMEOUT.
- Address at limit: exactly REGION_LIMIT[i] is not in region i.

Test Plan:
- Read 0x0004 (region 0, W=0), iRegionData slice0=0xDEADBEEF → oSelect=0001 at edge+1, oReady one cycle later, oReadData=0xDEADBEEF, oError=0.
- Read 0x1FFC (region 1, W=2), then 0x2000 → region 1 oReady 3 cycles after accept, region 2 (W=1) after 2; 0x2000 selects 0100, not 0010.
- Read 0x5000 (unmapped) → oReady next cycle, oReadData=0, oError=1, oErrorAddress=0x5000; a second fault at 0x6000 keeps 0x5000; iErrorClear then clears oError.
- Region 3 with iRegionReady[3]=0 held → oReady at 1+TIMEOUT=17 cycles, data 0, oError=1, oErrorAddress=0x2010; the same edge asserting iErrorClear leaves oError=1.
- Write 0x1000 → oWrite=1 with oSelect=0010, oReadData unchanged from the previous read, oReady after 3 cycles.
- Region 1 access with iRequest dropped after 1 cycle, and a separate access with iBusReset pulsed low mid-ACCESS → oSelect=0 immediately (reset asynchronous), no oReady, all outputs at reset values.
